vlsu_burst: RTL and testbench
=============================

# vlsu_burst

Parametrised successor to the memory-stage vector load/store unit. It serves the M stage of the SIMD pipeline and supports:

- scalar element loads and stores,
- multi-beat vector loads and stores where `WIDTH_V` is any integer multiple of the RAM line width,
- a new broadcast-load mode that replicates one element across all lanes.

It drives the single-port line-wide data RAM and raises `busy` to stall the pipeline until the access completes.

## Interface
Parameters:
- `WIDTH_V`, default 512: vector register width in bits. Must equal `BEATS*RAM_W`, with BEATS in 1..8.
- `RAM_W`, default 256: RAM line width in bits. Must be a power of two, at least 32.
- `ADDR_W`, default 14: RAM line-address width.
- `ELEM_W`, default 16: scalar element width. `ELEM_W` is 8 or 16.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `rd_en`  in  1: load request. Held stable while `busy`.
- `wr_en`  in  1: store request. Held stable while `busy`. Wins if asserted together with `rd_en`.
- `vec_en`  in  1: selects a vector access (else scalar).
- `bcast_en`  in  1: broadcast load. Ignored unless `rd_en` and not `vec_en`.
- `addr`  in  32: byte address. Line index is `addr[OFS+ADDR_W-1:OFS]`, where `OFS=log2(RAM_W/8)`.
- `sdata_in`  in  `ELEM_W`: scalar store data.
- `vdata_in`  in  `WIDTH_V`: vector store data.
- `busy`  out  1: pipeline stall request.
- `done`  out  1: one-cycle pulse in the completion cycle.
- `misalign_err`  out  1: valid with `done`.
- `sdata_out`  out  32: loaded element, zero-extended.
- `vdata_out`  out  `WIDTH_V`: loaded vector.
- `ram_rdata`  in  `RAM_W`: RAM read data, 1-cycle registered latency.
- `ram_rden`, `ram_wren`  out  1: RAM read and write strobes.
- `ram_addr`  out  `ADDR_W`: RAM line address.
- `ram_byteena`  out  `RAM_W/8`: RAM byte enables.
- `ram_wdata`  out  `RAM_W`: RAM write data.

## Operation
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: any request (`rd_en|wr_en`) starts an access.
  - DONE always returns to IDLE. The pipeline advances at the end of DONE, so any request seen in the following IDLE is a new one.
- `busy` is asserted in these cases, and is 0 in DONE and in IDLE without a request:
  - combinationally, in an IDLE cycle with a request;
  - in every RD and WR cycle.
- Beat counter `k` is `clog2(BEATS)+1` bits. Beat k uses `ram_addr = line + k`, wrapping modulo 2^`ADDR_W`, and covers `vdata[k*RAM_W +: RAM_W]`.
- Element placement: for byte offset `o = addr[OFS-1:0]`, the element occupies line bits `[o*8 +: ELEM_W]`.
- Scalar load:
  - Read 1 line and extract the element.
  - `sdata_out` = element zero-extended.
  - `vdata_out` = element in bits `[ELEM_W-1:0]`, zeros elsewhere.
- Broadcast load: same as scalar load, except `vdata_out` = element replicated `WIDTH_V/ELEM_W` times.
- Vector load:
  - Reads are pipelined: issue beats 0..B-1 on consecutive cycles, capture beat k one cycle after its issue.
  - `sdata_out` = lane 0 zero-extended.
- Scalar store: 1 write.
  - `ram_byteena` has `ELEM_W/8` bits set at offset o.
  - `ram_wdata` = `sdata_in` replicated across the line.
- Vector store: B writes on consecutive cycles, all byte enables set.
- Alignment and `misalign_err`:
  - Vector: `misalign_err`=1 if `addr[OFS-1:0]` is non-zero; the offset is ignored.
  - Scalar with `ELEM_W`=16: `misalign_err`=1 if `addr[0]`=1; bit 0 is treated as 0.
  - In both cases the access still completes.
- Outputs `sdata_out`, `vdata_out` and `misalign_err` are registered, and hold their value until the next load's DONE (`misalign_err`: until the next DONE).
- Reset:
  - While `reset`=1: `busy`, `done`, `ram_rden` and `ram_wren` are forced to 0 combinationally.
  - At the clock edge: state goes to IDLE, k=0, and `sdata_out`, `vdata_out`, `misalign_err` are cleared to 0.
  - Reset mid-access abandons the access; no further RAM strobes are issued.
- When idle: `ram_addr`, `ram_wdata` and `ram_byteena` are 0, and both strobes are 0.

## Timing
Cycle 0 is the IDLE cycle in which a request first appears.

- Scalar or broadcast load:
  - C0: `ram_rden`=1, `busy`=1.
  - C1 (RD): capture `ram_rdata`, `busy`=1.
  - C2 (DONE): `done`=1, `busy`=0, outputs valid.
- Vector load:
  - `ram_rden`=1 in C0..C(B-1).
  - Beats are captured in C1..CB.
  - DONE in C(B+1).
  - Total stall is B+1 cycles.
- Scalar store:
  - C0: `ram_wren`=1.
  - C1: DONE.
- Vector store:
  - `ram_wren`=1 in C0..C(B-1).
  - DONE in CB.
- Back-to-back requests: at most one IDLE cycle separates accesses. The next request can start in the cycle after DONE.

## Test plan
1. Reset, then default parameters. Scalar load at `addr`=0x46; RAM line 2 holds 0xBEEF at byte 6. Required:
   - `ram_addr`=2 and `ram_rden` in C0;
   - `busy` high for C0–C1;
   - C2: `done`=1, `sdata_out`=0x0000BEEF, `misalign_err`=0.
2. Scalar store of 0x1234 at `addr`=0x2A. Required:
   - C0: `ram_addr`=1, `ram_byteena`=0x00000C00, `ram_wdata` bits [95:80]=0x1234;
   - C1: `done`=1.
3. Vector load at `addr`=0x7FFE0 (line 0x3FFF), B=2. Required:
   - `ram_addr` = 0x3FFF in C0, then 0x0000 in C1 (wrap);
   - C3: `done`, with `vdata_out` = {line0, line0x3FFF}.
4. Vector store at `addr`=0x41. Required:
   - `misalign_err`=1 in DONE (C2);
   - lines 2 and 3 written with `vdata_in[255:0]` and `vdata_in[511:256]`;
   - `ram_byteena`=all ones.
5. Broadcast load of 0xA5A5 (`ELEM_W`=16). Required: `vdata_out` = 32 copies of 0xA5A5 in C2.
6. Assert `reset` in C1 of a vector store. Required:
   - `ram_wren`=0 from that cycle onward;
   - state IDLE, `busy`=0, `done` never pulses;
   - the next request proceeds normally.

Source files
------------

// File: rtl/vlsu_burst_if.sv
// Signal bundle between the M-stage pipeline, the burst load/store unit and
// the single-port line-wide data RAM.
interface vlsu_burst_if #(
    parameter int WIDTH_V = 512,
    parameter int RAM_W   = 256,
    parameter int ADDR_W  = 14,
    parameter int ELEM_W  = 16
);
    logic                 rd_en;
    logic                 wr_en;
    logic                 vec_en;
    logic                 bcast_en;
    logic [31:0]          addr;
    logic [ELEM_W-1:0]    sdata_in;
    logic [WIDTH_V-1:0]   vdata_in;
    logic                 busy;
    logic                 done;
    logic                 misalign_err;
    logic [31:0]          sdata_out;
    logic [WIDTH_V-1:0]   vdata_out;
    logic [RAM_W-1:0]     ram_rdata;
    logic                 ram_rden;
    logic                 ram_wren;
    logic [ADDR_W-1:0]    ram_addr;
    logic [RAM_W/8-1:0]   ram_byteena;
    logic [RAM_W-1:0]     ram_wdata;

    modport slave (
        input  rd_en, wr_en, vec_en, bcast_en, addr, sdata_in, vdata_in, ram_rdata,
        output busy, done, misalign_err, sdata_out, vdata_out,
               ram_rden, ram_wren, ram_addr, ram_byteena, ram_wdata
    );

    modport master (
        output rd_en, wr_en, vec_en, bcast_en, addr, sdata_in, vdata_in, ram_rdata,
        input  busy, done, misalign_err, sdata_out, vdata_out,
               ram_rden, ram_wren, ram_addr, ram_byteena, ram_wdata
    );
endinterface

// File: rtl/vlsu_burst.sv
// M-stage vector load/store unit: scalar, broadcast and multi-beat vector
// accesses to a line-wide single-port RAM, stalling the pipeline via busy.
module vlsu_burst #(
    parameter int WIDTH_V = 512,
    parameter int RAM_W   = 256,
    parameter int ADDR_W  = 14,
    parameter int ELEM_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    vlsu_burst_if.slave bus
);
    localparam int BEATS = WIDTH_V / RAM_W;
    localparam int BYTES = RAM_W / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int KW    = $clog2(BEATS) + 1;
    localparam int EB    = ELEM_W / 8;
    localparam int LANES = WIDTH_V / ELEM_W;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t               state;
    logic [KW-1:0]        k;
    logic [31:0]          sdata_q;
    logic [WIDTH_V-1:0]   vdata_q;
    logic                 mis_q;
    logic [WIDTH_V-1:0]   vbuf;

    logic                 req;
    logic                 is_wr;
    logic                 vec;
    logic                 bcast;
    logic                 mis;
    logic [KW-1:0]        nbeats;
    logic [KW-1:0]        cap;
    logic [ADDR_W-1:0]    line;
    logic [OFS-1:0]       ofs_raw;
    logic [OFS-1:0]       ofs;
    logic [ELEM_W-1:0]    elem;
    logic [WIDTH_V-1:0]   merged;
    logic                 unused_addr;

    assign unused_addr = ^bus.addr[31:OFS+ADDR_W];

    // Request decode; inputs are held stable by the pipeline for the whole access.
    always_comb begin
        req     = bus.rd_en | bus.wr_en;
        is_wr   = bus.wr_en;
        vec     = bus.vec_en;
        bcast   = bus.rd_en & ~bus.wr_en & ~bus.vec_en & bus.bcast_en;
        nbeats  = vec ? KW'(BEATS) : KW'(1);
        line    = bus.addr[OFS+ADDR_W-1:OFS];
        ofs_raw = bus.addr[OFS-1:0];
        ofs     = ofs_raw;
        if (ELEM_W == 16) ofs[0] = 1'b0;
        mis     = vec ? (ofs_raw != '0) : ((ELEM_W == 16) && bus.addr[0]);
        elem    = bus.ram_rdata[ofs*8 +: ELEM_W];
        cap     = k - KW'(1);
        merged  = vbuf;
        merged[cap*RAM_W +: RAM_W] = bus.ram_rdata;
    end

    // RAM strobes: beat 0 issues from IDLE so the access starts in the request cycle.
    always_comb begin
        bus.ram_rden    = 1'b0;
        bus.ram_wren    = 1'b0;
        bus.ram_addr    = '0;
        bus.ram_byteena = '0;
        bus.ram_wdata   = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        bus.ram_addr = line;
                        if (is_wr) begin
                            bus.ram_wren = 1'b1;
                            if (vec) begin
                                bus.ram_byteena = '1;
                                bus.ram_wdata   = bus.vdata_in[RAM_W-1:0];
                            end else begin
                                bus.ram_byteena = BYTES'({EB{1'b1}}) << ofs;
                                bus.ram_wdata   = {(RAM_W/ELEM_W){bus.sdata_in}};
                            end
                        end else begin
                            bus.ram_rden = 1'b1;
                        end
                    end
                end
                RD: begin
                    if (k < nbeats) begin
                        bus.ram_rden = 1'b1;
                        bus.ram_addr = line + ADDR_W'(k);
                    end
                end
                WR: begin
                    bus.ram_wren    = 1'b1;
                    bus.ram_addr    = line + ADDR_W'(k);
                    bus.ram_byteena = '1;
                    bus.ram_wdata   = bus.vdata_in[k*RAM_W +: RAM_W];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = !reset && ((state == IDLE && req) || state == RD || state == WR);
    assign bus.done = !reset && (state == DONE);
    assign bus.sdata_out    = sdata_q;
    assign bus.vdata_out    = vdata_q;
    assign bus.misalign_err = mis_q;

    // In RD, k counts beats issued; the beat captured this cycle is k-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            sdata_q <= '0;
            vdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!is_wr) begin
                            state <= RD;
                            k     <= KW'(1);
                        end else if (nbeats == KW'(1)) begin
                            state <= DONE;
                            mis_q <= mis;
                        end else begin
                            state <= WR;
                            k     <= KW'(1);
                        end
                    end
                end
                RD: begin
                    if (k == nbeats) begin
                        state <= DONE;
                        k     <= '0;
                        mis_q <= mis;
                        if (vec) begin
                            vdata_q <= merged;
                            sdata_q <= 32'(merged[ELEM_W-1:0]);
                        end else begin
                            sdata_q <= 32'(elem);
                            vdata_q <= bcast ? {LANES{elem}} : WIDTH_V'(elem);
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                WR: begin
                    if (k + KW'(1) == nbeats) begin
                        state <= DONE;
                        k     <= '0;
                        mis_q <= mis;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == RD) vbuf <= merged;
    end
endmodule

// File: tb/tb_vlsu_burst.sv
// Scoreboard bench for vlsu_burst: behavioural RAM, line-level reference model,
// directed scenarios followed by randomized accesses.
module tb_vlsu_burst;
    localparam int WIDTH_V = 512;
    localparam int RAM_W   = 256;
    localparam int ADDR_W  = 14;
    localparam int ELEM_W  = 16;
    localparam int B       = WIDTH_V / RAM_W;
    localparam int NL      = 1 << ADDR_W;
    localparam int NBY     = RAM_W / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vlsu_burst_if #(.WIDTH_V(WIDTH_V), .RAM_W(RAM_W), .ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) bus ();
    vlsu_burst #(.WIDTH_V(WIDTH_V), .RAM_W(RAM_W), .ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RAM_W-1:0] init_line(input int a);
        logic [RAM_W-1:0] v;
        logic [31:0] aa;
        aa = a;
        for (int j = 0; j < RAM_W/32; j++)
            v[j*32 +: 32] = (aa * 32'h9E3779B1) ^ (j * 32'h85EBCA6B) ^ 32'h5A5A0F0F;
        return v;
    endfunction

    // Behavioural single-port RAM with one-cycle registered read.
    logic [RAM_W-1:0] ram [NL];
    bit               ram_wr [NL];
    logic             pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_line;
    logic [RAM_W-1:0] pre_data;

    function automatic logic [RAM_W-1:0] merge_be(input logic [RAM_W-1:0] old,
                                                  input logic [RAM_W-1:0] wd,
                                                  input logic [NBY-1:0] be);
        logic [RAM_W-1:0] r;
        r = old;
        for (int b = 0; b < NBY; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_rden)
            bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram[bus.ram_addr] : init_line(int'(bus.ram_addr));
        if (bus.ram_wren) begin
            ram[bus.ram_addr] <= merge_be(ram_wr[bus.ram_addr] ? ram[bus.ram_addr] : init_line(int'(bus.ram_addr)),
                                          bus.ram_wdata, bus.ram_byteena);
            ram_wr[bus.ram_addr] <= 1'b1;
        end
        if (pre_en) begin
            ram[pre_line]    <= pre_data;
            ram_wr[pre_line] <= 1'b1;
        end
    end

    // Reference model: memory image plus the architecturally visible load outputs.
    logic [RAM_W-1:0]   mdl [NL];
    bit                 mdl_wr [NL];
    logic [31:0]        m_sdata = '0;
    logic [WIDTH_V-1:0] m_vdata = '0;
    logic               m_mis = 1'b0;

    function automatic logic [RAM_W-1:0] mdl_rd(input int a);
        int x;
        x = a % NL;
        return mdl_wr[x] ? mdl[x] : init_line(x);
    endfunction

    typedef struct {
        int                 start;
        int                 lat;
        logic [31:0]        sdata;
        logic [WIDTH_V-1:0] vdata;
        logic               mis;
    } exp_t;
    exp_t expq[$];
    exp_t e;

    logic               tr_busy [16];
    logic               tr_rden [16];
    logic               tr_wren [16];
    logic [ADDR_W-1:0]  tr_addr [16];
    logic [NBY-1:0]     tr_be [16];
    logic [RAM_W-1:0]   tr_wdata [16];
    int                 nt;

    task automatic preload(input int ln, input logic [RAM_W-1:0] d);
        @(posedge clk); #1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        pre_en = 1'b1; pre_line = ADDR_W'(ln); pre_data = d;
        mdl[ln] = d; mdl_wr[ln] = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        end
    endtask

    task automatic access(input bit wr, input bit rd, input bit vec, input bit bc,
                          input logic [31:0] a, input logic [15:0] sd, input logic [WIDTH_V-1:0] vd);
        int line, o, nb, lat;
        bit got, mis;
        logic [RAM_W-1:0] t;
        logic [15:0] el;
        exp_t x;
        line = int'((a >> 5) & (NL - 1));
        o    = int'(a & 32'd31);
        nb   = vec ? B : 1;
        mis  = vec ? (o != 0) : a[0];
        if (!vec) o = o & ~1;
        if (wr) begin
            lat = nb;
            if (vec) begin
                for (int i = 0; i < B; i++) begin
                    mdl[(line + i) % NL] = vd[i*RAM_W +: RAM_W];
                    mdl_wr[(line + i) % NL] = 1'b1;
                end
            end else begin
                t = mdl_rd(line);
                t[o*8 +: 16] = sd;
                mdl[line] = t; mdl_wr[line] = 1'b1;
            end
        end else begin
            lat = nb + 1;
            if (vec) begin
                for (int i = 0; i < B; i++) m_vdata[i*RAM_W +: RAM_W] = mdl_rd(line + i);
                m_sdata = {16'h0, m_vdata[15:0]};
            end else begin
                t  = mdl_rd(line);
                el = t[o*8 +: 16];
                m_sdata = {16'h0, el};
                m_vdata = bc ? {(WIDTH_V/16){el}} : {{(WIDTH_V-16){1'b0}}, el};
            end
        end
        m_mis = mis;
        @(posedge clk); #1;
        bus.wr_en = wr; bus.rd_en = rd; bus.vec_en = vec; bus.bcast_en = bc;
        bus.addr = a; bus.sdata_in = sd; bus.vdata_in = vd;
        x.start = cyc; x.lat = lat; x.sdata = m_sdata; x.vdata = m_vdata; x.mis = m_mis;
        expq.push_back(x);
        got = 1'b0; nt = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            tr_busy[i] = bus.busy; tr_rden[i] = bus.ram_rden; tr_wren[i] = bus.ram_wren;
            tr_addr[i] = bus.ram_addr; tr_be[i] = bus.ram_byteena; tr_wdata[i] = bus.ram_wdata;
            if (bus.done) begin got = 1'b1; nt = i; end
        end
        chk("done_seen", got, 1);
        if (got) begin
            for (int i = 0; i <= nt; i++) begin
                chk($sformatf("busy_c%0d", i), tr_busy[i], i < lat);
                chk($sformatf("strobe_c%0d", i), wr ? tr_wren[i] : tr_rden[i], i < nb);
                chk($sformatf("other_strobe_c%0d", i), wr ? tr_rden[i] : tr_wren[i], 0);
                if (i < nb) chk($sformatf("ram_addr_c%0d", i), tr_addr[i], (line + i) % NL);
                if (wr && i < nb) begin
                    chk($sformatf("byteena_c%0d", i), tr_be[i], vec ? {NBY{1'b1}} : (32'h3 << o));
                    chk($sformatf("wdata_c%0d", i), tr_wdata[i], vec ? vd[i*RAM_W +: RAM_W] : {(RAM_W/16){sd}});
                end
            end
        end
    endtask

    // Monitor: every done pulse retires the oldest expected response.
    always @(negedge clk) begin
        if (bus.done) begin
            if (expq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("done_latency", cyc - e.start, e.lat);
                chk("sdata_out", bus.sdata_out, e.sdata);
                chk("vdata_out", bus.vdata_out, e.vdata);
                chk("misalign_err", bus.misalign_err, e.mis);
                chk("busy_in_done", bus.busy, 0);
            end
        end
        if (!reset && !bus.rd_en && !bus.wr_en)
            chk("idle_quiet", {bus.busy, bus.done, bus.ram_rden, bus.ram_wren,
                               bus.ram_addr, bus.ram_byteena, bus.ram_wdata}, 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [RAM_W-1:0] t;
        logic [WIDTH_V-1:0] vd, vd2;
        int op, ln;
        logic [31:0] a;
        reset = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.vec_en = 1'b0; bus.bcast_en = 1'b0;
        bus.addr = '0; bus.sdata_in = '0; bus.vdata_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {bus.busy, bus.done, bus.ram_rden, bus.ram_wren}, 0);
        chk("rst_outputs", {bus.sdata_out, bus.misalign_err}, 0);
        chk("rst_vdata", bus.vdata_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Scalar load of 0xBEEF from line 2, byte 6.
        t = init_line(2); t[63:48] = 16'hBEEF;
        preload(2, t);
        access(0, 1, 0, 0, 32'h46, 16'h0, '0);
        chk("t1_addr", tr_addr[0], 2);
        chk("t1_rden", tr_rden[0], 1);
        chk("t1_done_c2", nt, 2);
        chk("t1_sdata", bus.sdata_out, 32'h0000BEEF);
        chk("t1_mis", bus.misalign_err, 0);

        // Scalar store of 0x1234 at 0x2A.
        access(1, 0, 0, 0, 32'h2A, 16'h1234, '0);
        chk("t2_addr", tr_addr[0], 1);
        chk("t2_be", tr_be[0], 32'h00000C00);
        chk("t2_wdata", tr_wdata[0][95:80], 16'h1234);
        chk("t2_done_c1", nt, 1);
        chk("t2_hold_sdata", bus.sdata_out, 32'h0000BEEF);

        // Vector load wrapping from the last line to line 0.
        access(0, 1, 1, 0, 32'h7FFE0, 16'h0, '0);
        chk("t3_addr_c0", tr_addr[0], 14'h3FFF);
        chk("t3_addr_c1", tr_addr[1], 14'h0000);
        chk("t3_done_c3", nt, 3);
        chk("t3_vdata", bus.vdata_out, {mdl_rd(0), mdl_rd(14'h3FFF)});

        // Misaligned vector store at 0x41, then read it back.
        for (int j = 0; j < WIDTH_V/32; j++) vd[j*32 +: 32] = $urandom;
        access(1, 0, 1, 0, 32'h41, 16'h0, vd);
        chk("t4_done_c2", nt, 2);
        chk("t4_mis", bus.misalign_err, 1);
        chk("t4_addr", {tr_addr[0], tr_addr[1]}, {14'd2, 14'd3});
        chk("t4_be", {tr_be[0], tr_be[1]}, {64{1'b1}});
        chk("t4_beat0", tr_wdata[0], vd[255:0]);
        chk("t4_beat1", tr_wdata[1], vd[511:256]);
        access(0, 1, 1, 0, 32'h40, 16'h0, '0);
        chk("t4_readback", bus.vdata_out, vd);

        // Broadcast load of 0xA5A5.
        t = init_line(9); t[111:96] = 16'hA5A5;
        preload(9, t);
        access(0, 1, 0, 1, (32'd9 << 5) | 32'd12, 16'h0, '0);
        chk("t5_bcast", bus.vdata_out, {32{16'hA5A5}});
        chk("t5_sdata", bus.sdata_out, 32'h0000A5A5);

        // Reset in C1 of a vector store abandons it after beat 0.
        for (int j = 0; j < WIDTH_V/32; j++) vd2[j*32 +: 32] = $urandom;
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.vec_en = 1'b1; bus.bcast_en = 1'b0;
        bus.addr = 32'd5 << 5; bus.vdata_in = vd2;
        mdl[5] = vd2[255:0]; mdl_wr[5] = 1'b1;
        @(negedge clk);
        chk("t6_wren_c0", bus.ram_wren, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_in_reset", {bus.ram_wren, bus.busy, bus.done}, 0);
        @(posedge clk); #1;
        reset = 1'b0; bus.wr_en = 1'b0; bus.vec_en = 1'b0;
        m_sdata = '0; m_vdata = '0; m_mis = 1'b0;
        @(negedge clk);
        chk("t6_after", {bus.ram_wren, bus.busy, bus.done}, 0);
        chk("t6_cleared", {bus.sdata_out, bus.misalign_err}, 0);
        chk("t6_vcleared", bus.vdata_out, 0);
        idle(3);
        access(0, 1, 1, 0, 32'd5 << 5, 16'h0, '0);
        chk("t6_next_beat0", bus.vdata_out[255:0], vd2[255:0]);

        // Randomized mix over a small line window including the wrap point.
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 99);
            ln = $urandom_range(0, 9);
            if (ln >= 8) ln = NL - 1 - (ln - 8);
            a = (32'(ln) << 5) | 32'($urandom_range(0, 31));
            for (int j = 0; j < WIDTH_V/32; j++) vd[j*32 +: 32] = $urandom;
            if (op < 30)      access(0, 1, 0, 0, a, 16'($urandom), vd);
            else if (op < 45) access(0, 1, 0, 1, a, 16'($urandom), vd);
            else if (op < 65) access(0, 1, 1, 1'($urandom), a, 16'($urandom), vd);
            else if (op < 85) access(1, 1'($urandom), 0, 1'($urandom), a, 16'($urandom), vd);
            else              access(1, 1'($urandom), 1, 1'($urandom), a, 16'($urandom), vd);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
